// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter for the 32x32 register file write port.
// Round-robin selects one of N_REQ requesters per cycle, registers the winning
// write onto wen/waddr/wdata, and keeps a pending-write scoreboard that issue
// logic uses to stall on RAW hazards against writes still in flight.
module reg_wb_arbiter #(
    parameter int N_REQ      = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic                          wen,
    output logic [ADDR_WIDTH-1:0]         waddr,
    output logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          sb_set_valid,
    input  logic [ADDR_WIDTH-1:0]         sb_set_addr,
    output logic [(1<<ADDR_WIDTH)-1:0]    pending
);

    localparam int              PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int              N_REGS    = 1 << ADDR_WIDTH;
    localparam logic [PTR_W:0]  N_REQ_EXT = (PTR_W + 1)'(N_REQ);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Round-robin pointer: the requester searched first this cycle.
    logic [PTR_W-1:0]      ptr_q;
    logic [PTR_W-1:0]      ptr_d;

    // Arbitration result.
    logic                  found_s;
    logic [PTR_W-1:0]      grant_idx_s;
    logic [PTR_W-1:0]      cand_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_data_s;

    // Registered write port.
    logic                  wen_q;
    logic                  wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [ADDR_WIDTH-1:0] waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wdata_d;

    // Scoreboard of outstanding writes.
    logic [N_REGS-1:0]     pending_q;
    logic [N_REGS-1:0]     pending_d;

    // Index addition modulo N_REQ; the wrap is explicit so non-power-of-two
    // requester counts never select a non-existent requester.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input logic [PTR_W-1:0] off);
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= N_REQ_EXT) begin
            sum = sum - N_REQ_EXT;
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    // Search from ptr upward (wrapping) and pick the first valid requester.
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = {PTR_W{1'b0}};
        cand_s      = {PTR_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = wrap_add(ptr_q, PTR_W'(k));
            if (!found_s && req_valid[cand_s]) begin
                found_s     = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                found_s     = found_s;
            end
        end
    end

    // One-hot ready for the winner and mux of its payload.
    always_comb begin
        req_ready  = {N_REQ{1'b0}};
        sel_addr_s = {ADDR_WIDTH{1'b0}};
        sel_data_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx_s == PTR_W'(i)) begin
                req_ready[i] = found_s;
                sel_addr_s   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data_s   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    // Next pointer: one past the winner, or hold when nobody was granted.
    always_comb begin
        if (found_s) begin
            ptr_d = wrap_add(grant_idx_s, PTR_ONE);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Next write-port value; writes to register 0 are consumed but suppressed.
    always_comb begin
        if (found_s) begin
            wen_d   = (sel_addr_s != {ADDR_WIDTH{1'b0}});
            waddr_d = sel_addr_s;
            wdata_d = sel_data_s;
        end else begin
            wen_d   = 1'b0;
            waddr_d = waddr_q;
            wdata_d = wdata_q;
        end
    end

    // Scoreboard update: retire the write on the port now, then apply a new
    // issue-side set so a fresh producer to the same register keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (wen_q) begin
            pending_d[waddr_q] = 1'b0;
        end else begin
            pending_d = pending_d;
        end
        if (sb_set_valid && (sb_set_addr != {ADDR_WIDTH{1'b0}})) begin
            pending_d[sb_set_addr] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
        pending_d[0] = 1'b0;
    end

    // State registers: pointer, write port and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= {PTR_W{1'b0}};
            wen_q     <= 1'b0;
            waddr_q   <= {ADDR_WIDTH{1'b0}};
            wdata_q   <= {DATA_WIDTH{1'b0}};
            pending_q <= {N_REGS{1'b0}};
        end else begin
            ptr_q     <= ptr_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
        end
    end

    assign wen     = wen_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: expected writes are queued as grants are
// observed and a negedge monitor pops and compares them when wen is high.
module tb_reg_wb_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic              wen;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic              sb_set_valid;
    logic [AW-1:0]     sb_set_addr;
    logic [(1<<AW)-1:0] pending;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  total = 0;
    int  bad   = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .sb_set_valid(sb_set_valid),
        .sb_set_addr (sb_set_addr),
        .pending     (pending)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every register-file write must match the oldest expected one.
    always @(negedge clk) begin
        if (wen === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", waddr, wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (waddr !== mon_e.a || wdata !== mon_e.d) begin
                    bad++;
                    $display("FAIL wr_data: got addr %0h data %0h expected addr %0h data %0h",
                             waddr, wdata, mon_e.a, mon_e.d);
                end
            end
        end
    end

    logic [DW-1:0] dat [N];

    initial begin
        dat[0] = 32'h0000_00A1;
        dat[1] = 32'h0000_00B2;
        dat[2] = 32'h0000_00C3;
        rst          = 1'b1;
        req_valid    = 3'b111;
        req_addr     = '0;
        req_data     = '0;
        sb_set_valid = 1'b0;
        sb_set_addr  = 5'd0;
        for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), dat[i]);

        // Reset with all requesters valid
        sample(); chk("rst_wen_0", {63'd0, wen}, 64'd0); chk("rst_pend_0", {32'd0, pending}, 64'd0);
        sample(); chk("rst_wen_1", {63'd0, wen}, 64'd0); chk("rst_pend_1", {32'd0, pending}, 64'd0);
        step(); rst = 1'b0;
        sample(); chk("rst_ready", {61'd0, req_ready}, 64'd1); push(5'd1, dat[0]);

        // Round robin over three continuously valid requesters
        for (int c = 1; c < 6; c++) begin
            step();
            sample();
            chk("rr_ready", {61'd0, req_ready}, 64'd1 << (c % 3));
            chk("rr_wen", {63'd0, wen}, 64'd1);
            push(AW'((c % 3) + 1), dat[c % 3]);
        end
        step(); req_valid = 3'b000;
        sample(); chk("idle_ready", {61'd0, req_ready}, 64'd0);

        // Single requester 2, skipping 0 and 1
        step(); req_valid = 3'b100; set_req(2, 5'd7, 32'hDEAD_BEEF);
        sample(); chk("skip_ready", {61'd0, req_ready}, 64'd4); push(5'd7, 32'hDEAD_BEEF);
        step(); req_valid = 3'b000;
        sample();
        step(); req_valid = 3'b111; set_req(2, 5'd3, dat[2]);
        sample();
        chk("skip_ptr", {61'd0, req_ready}, 64'd1);
        chk("hold_wen", {63'd0, wen}, 64'd0);
        chk("hold_waddr", {59'd0, waddr}, 64'd7);
        chk("hold_wdata", {32'd0, wdata}, 64'hDEAD_BEEF);
        push(5'd1, dat[0]);
        step(); req_valid = 3'b000;
        sample();

        // Write to register 0 is consumed but not performed
        step(); req_valid = 3'b010; set_req(1, 5'd0, 32'h5);
        sample(); chk("a0_ready", {61'd0, req_ready}, 64'd2);
        step(); req_valid = 3'b000;
        sample(); chk("a0_wen", {63'd0, wen}, 64'd0); chk("a0_pend", {32'd0, pending}, 64'd0);
        step(); req_valid = 3'b011; set_req(1, 5'd2, dat[1]);
        sample(); chk("a0_ptr", {61'd0, req_ready}, 64'd1); push(5'd1, dat[0]);
        step(); req_valid = 3'b000;
        sample();

        // Scoreboard lifecycle on register 9
        step(); sb_set_valid = 1'b1; sb_set_addr = 5'd9;
        sample(); chk("sb_c0", {32'd0, pending}, 64'd0);
        step(); sb_set_valid = 1'b0;
        sample(); chk("sb_c1", {32'd0, pending}, 64'd1 << 9);
        step();
        sample(); chk("sb_c2", {32'd0, pending}, 64'd1 << 9);
        step(); req_valid = 3'b001; set_req(0, 5'd9, 32'h99);
        sample(); chk("sb_c3_ready", {61'd0, req_ready}, 64'd1); chk("sb_c3", {32'd0, pending}, 64'd1 << 9);
        push(5'd9, 32'h99);
        step(); req_valid = 3'b000; set_req(0, 5'd1, dat[0]);
        sample(); chk("sb_c4", {32'd0, pending}, 64'd1 << 9);
        step();
        sample(); chk("sb_c5", {32'd0, pending}, 64'd0);

        // Set and clear of register 4 in the same cycle: set wins
        step(); sb_set_valid = 1'b1; sb_set_addr = 5'd4;
        sample();
        step(); sb_set_valid = 1'b0; req_valid = 3'b010; set_req(1, 5'd4, 32'h44);
        sample(); chk("col_ready", {61'd0, req_ready}, 64'd2); chk("col_pend0", {32'd0, pending}, 64'd1 << 4);
        push(5'd4, 32'h44);
        step(); req_valid = 3'b000; sb_set_valid = 1'b1; sb_set_addr = 5'd4;
        sample(); chk("col_pend1", {32'd0, pending}, 64'd1 << 4);
        step(); sb_set_valid = 1'b0;
        sample(); chk("col_set_wins", {32'd0, pending}, 64'd1 << 4);

        // Same collision but set targets register 0: clear applies
        step(); req_valid = 3'b100; set_req(2, 5'd4, 32'h55);
        sample(); chk("col0_ready", {61'd0, req_ready}, 64'd4); push(5'd4, 32'h55);
        step(); req_valid = 3'b000; sb_set_valid = 1'b1; sb_set_addr = 5'd0;
        sample(); chk("col0_pend1", {32'd0, pending}, 64'd1 << 4);
        step(); sb_set_valid = 1'b0;
        sample(); chk("col0_clear", {32'd0, pending}, 64'd0);

        // Reset during a grant cycle drops the write and resets ptr
        step(); sb_set_valid = 1'b1; sb_set_addr = 5'd12;
        sample();
        step(); sb_set_valid = 1'b0; rst = 1'b1; req_valid = 3'b110;
        set_req(1, 5'd5, 32'h51); set_req(2, 5'd6, 32'h62);
        sample(); chk("mrst_pend_pre", {32'd0, pending}, 64'd1 << 12);
        step(); rst = 1'b0;
        sample();
        chk("mrst_wen", {63'd0, wen}, 64'd0);
        chk("mrst_pend", {32'd0, pending}, 64'd0);
        chk("mrst_ptr", {61'd0, req_ready}, 64'd2);
        push(5'd5, 32'h51);
        step(); req_valid = 3'b000;
        sample();
        step();
        sample();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file among N writeback requesters, e.g. ALU, load unit and multi-cycle mul/div.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Registers the winning write before it drives the register file's wen/waddr/wdata.
- Keeps a pending-write scoreboard so issue logic can stall on RAW hazards against in-flight writes.

Parameters:
- N_REQ, 3, number of writeback requesters (2..8).
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register address width; the register file has 2^ADDR_WIDTH entries, and entry 0 is hardwired to zero.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  N_REQ  per-requester write request.
- req_ready  output  N_REQ  per-requester grant; transfer occurs when valid & ready.
- req_addr  input  N_REQ*ADDR_WIDTH  packed destination addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  input  N_REQ*DATA_WIDTH  packed write data; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- wen  output  1  register-file write enable (registered).
- waddr  output  ADDR_WIDTH  register-file write address (registered).
- wdata  output  DATA_WIDTH  register-file write data (registered).
- sb_set_valid  input  1  issue stage marks a destination as pending.
- sb_set_addr  input  ADDR_WIDTH  destination being marked.
- pending  output  2^ADDR_WIDTH  scoreboard; bit k=1 means a write to register k is outstanding.

Behaviour:
- Reset (rst=1 at posedge):
  - wen=0, waddr=0, wdata=0, pending=0.
  - Round-robin pointer ptr=0.
  - req_ready is combinational from req_valid and ptr, so it follows the reset ptr in the next cycle.
  - Reset mid-transfer drops any registered write: wen=0 in the following cycle and no register-file write occurs.
- Arbitration (combinational, each cycle):
  - Search requesters ptr, ptr+1, ... (mod N_REQ); the first with req_valid=1 is granted.
  - At most one req_ready bit is high, and only for a valid requester.
  - If no requester is valid, req_ready=0.
- Pointer update:
  - On a grant to requester i, ptr <= (i+1) mod N_REQ.
  - With no grant, ptr holds.
- Output stage:
  - Grant in cycle t gives wen=1, waddr=req_addr[i], wdata=req_data[i] during cycle t+1.
  - The register file latches at the posedge ending t+1, so the data is readable from cycle t+2.
  - The output stage never stalls, so one write per cycle is sustained.
  - A cycle with no grant gives wen=0 next cycle; waddr/wdata hold their previous values.
- Address 0:
  - A request with addr 0 is granted and consumed normally (req_ready=1, ptr advances).
  - The registered wen is forced to 0.
- Requester rules:
  - Once req_valid is asserted, it and the payload stay stable until the transfer completes.
  - The arbiter behaviour is undefined if a requester retracts.
- Scoreboard:
  - Set: sb_set_valid=1 and sb_set_addr!=0 sets pending[sb_set_addr] at the posedge.
  - Clear: wen=1 in the current cycle clears pending[waddr] at the same posedge the register file is written.
  - Simultaneous set and clear on the same address: set wins, because a newer producer was issued.
  - Set and clear on different addresses both apply.
  - pending[0] is constant 0.
  - Clearing a bit that is not set is a no-op.
- Widths: no arithmetic beyond the ptr increment mod N_REQ; for non-power-of-two N_REQ the increment wraps explicitly.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with req_valid=3'b111, then rst=0 -> during reset cycles wen=0 and pending=0; first cycle after reset req_ready=3'b001 (ptr=0); following cycle wen=1.
- Round-robin fairness: all three requesters valid continuously with addrs 1,2,3 and data 0xA1,0xB2,0xC3 -> grants 0,1,2,0,1,2 on consecutive cycles; wen=1 every cycle; waddr sequence 1,2,3,1,... lagging the grants by one cycle.
- Single requester and skip: only req 2 valid, addr 7, data 0xDEADBEEF -> req_ready=3'b100 same cycle; next cycle wen=1, waddr=7, wdata=0xDEADBEEF; ptr becomes 0.
- Address 0 write: req 1 valid with addr 0, data 0x5 -> req_ready[1]=1; next cycle wen=0; pending unchanged.
- Scoreboard lifecycle: sb_set on addr 9 at cycle 0 -> pending[9]=1 from cycle 1; req 0 writes addr 9 granted at cycle 3 -> wen=1 in cycle 4; pending[9]=0 from cycle 5.
- Set/clear collision: wen=1, waddr=4 in the same cycle as sb_set_valid=1, sb_set_addr=4 -> pending[4] stays 1. Repeat with sb_set_addr=0 -> pending[4] clears and pending[0] remains 0.
